// File: rtl/mem_pkg.sv
// Shared types and widths for the line memory responder: line geometry, FSM states,
// and the latency counter width.
package mem_pkg;

  localparam int CACHE_LINE_WIDTH = 128;
  localparam int MAX_BIT_POS      = 31;
  localparam int LINE_OFFSET_BITS = 4;
  localparam int LAT_CNT_W        = 8;

  typedef enum logic [2:0] {
    IDLE,
    WB_BUSY,
    WB_DONE,
    RD_BUSY,
    RD_DONE
  } mem_state_t;

endpackage

// File: rtl/line_mem_array.sv
// DEPTH x WIDTH single-port line store with synchronous write and a registered read port.
// The read register is reset to zero, but the storage itself is not reset.
module line_mem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 128,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WIDTH-1:0] i_wr_dat,
  output logic [WIDTH-1:0] o_rd_dat
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_dat;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_idx] <= i_wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_dat <= '0;
    end else if (i_rd_en) begin
      r_rd_dat <= r_mem[i_idx];
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side line responder: handles one write-back or refill at a time, each completing MEM_LATENCY edges after acceptance.
// Requests are level handshakes held until done is seen. Defining LINE_MEM_STATS_EN adds the wb_count and refill_count ports.
module line_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int MEM_LATENCY = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        write_back_enable,
  input  logic [MAX_BIT_POS:0]        write_back_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] write_back_data,
  output logic                        write_back_finished,
  input  logic                        refill_req,
  input  logic [MAX_BIT_POS:0]        refill_addr,
  output logic [CACHE_LINE_WIDTH-1:0] ldata,
  output logic                        ldata_valid
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]                 wb_count,
  output logic [31:0]                 refill_count
`endif
);

  localparam int                   IDX_W    = $clog2(DEPTH);
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LATENCY);

  mem_state_t                  r_state;
  mem_state_t                  w_state_nxt;
  logic [LAT_CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]            r_idx;
  logic [CACHE_LINE_WIDTH-1:0] r_wb_dat;
  logic                        r_wb_fin;
  logic                        r_ldata_vld;
  logic                        w_cnt_done;
  logic                        w_wb_acc;
  logic                        w_rd_acc;
  logic                        w_wr_en;
  logic                        w_rd_en;
  logic                        w_rd_rel;
  logic                        w_unused_addr;

  // Only the line-index bits take part; offset and high bits alias.
  assign w_unused_addr = ^{write_back_addr[MAX_BIT_POS:IDX_W+LINE_OFFSET_BITS],
                           write_back_addr[LINE_OFFSET_BITS-1:0],
                           refill_addr[MAX_BIT_POS:IDX_W+LINE_OFFSET_BITS],
                           refill_addr[LINE_OFFSET_BITS-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_done  = (r_cnt == LAT_LAST);
    w_wb_acc    = 1'b0;
    w_rd_acc    = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_rd_rel    = 1'b0;
    case (r_state)
      IDLE: begin
        // A dirty victim must land before any refill that may read it back.
        if (write_back_enable) begin
          w_wb_acc    = 1'b1;
          w_state_nxt = WB_BUSY;
        end else if (refill_req) begin
          w_rd_acc    = 1'b1;
          w_state_nxt = RD_BUSY;
        end
      end
      WB_BUSY: begin
        if (w_cnt_done) begin
          w_wr_en     = 1'b1;
          w_state_nxt = WB_DONE;
        end
      end
      WB_DONE: begin
        if (!write_back_enable) begin
          w_state_nxt = IDLE;
        end
      end
      RD_BUSY: begin
        if (w_cnt_done) begin
          w_rd_en     = 1'b1;
          w_state_nxt = RD_DONE;
        end
      end
      RD_DONE: begin
        if (!refill_req) begin
          w_rd_rel    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter reads k on the k-th edge after acceptance, so completion lands on edge E0+MEM_LATENCY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_wb_acc || w_rd_acc) begin
      r_cnt <= LAT_CNT_W'(1);
    end else if (w_wr_en || w_rd_en) begin
      r_cnt <= '0;
    end else if ((r_state == WB_BUSY) || (r_state == RD_BUSY)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_wb_dat <= '0;
    end else if (w_wb_acc) begin
      r_idx    <= write_back_addr[IDX_W+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
      r_wb_dat <= write_back_data;
    end else if (w_rd_acc) begin
      r_idx    <= refill_addr[IDX_W+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_fin    <= 1'b1;
      r_ldata_vld <= 1'b0;
    end else begin
      if (w_wb_acc) begin
        r_wb_fin <= 1'b0;
      end else if (w_wr_en) begin
        r_wb_fin <= 1'b1;
      end
      if (w_rd_en) begin
        r_ldata_vld <= 1'b1;
      end else if (w_rd_rel) begin
        r_ldata_vld <= 1'b0;
      end
    end
  end

  line_mem_array #(
    .DEPTH (DEPTH),
    .WIDTH (CACHE_LINE_WIDTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_wr_en),
    .i_rd_en  (w_rd_en),
    .i_idx    (r_idx),
    .i_wr_dat (r_wb_dat),
    .o_rd_dat (ldata)
  );

  assign write_back_finished = r_wb_fin;
  assign ldata_valid         = r_ldata_vld;

`ifdef LINE_MEM_STATS_EN
  logic [31:0] r_wb_cnt;
  logic [31:0] r_rd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_wb_cnt <= r_wb_cnt + 32'd1;
      end
      if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end
    end
  end

  assign wb_count     = r_wb_cnt;
  assign refill_count = r_rd_cnt;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a transaction-level memory model is checked on every
// falling edge, alongside hand-computed literal expectations for each scenario.
module tb_line_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         write_back_enable = 1'b0;
  logic [31:0]  write_back_addr   = '0;
  logic [127:0] write_back_data   = '0;
  logic         write_back_finished;
  logic         refill_req  = 1'b0;
  logic [31:0]  refill_addr = '0;
  logic [127:0] ldata;
  logic         ldata_valid;
`ifdef LINE_MEM_STATS_EN
  logic [31:0]  wb_count;
  logic [31:0]  refill_count;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  line_mem_responder #(.DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .write_back_enable   (write_back_enable),
    .write_back_addr     (write_back_addr),
    .write_back_data     (write_back_data),
    .write_back_finished (write_back_finished),
    .refill_req          (refill_req),
    .refill_addr         (refill_addr),
    .ldata               (ldata),
    .ldata_valid         (ldata_valid)
`ifdef LINE_MEM_STATS_EN
    ,
    .wb_count            (wb_count),
    .refill_count        (refill_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 4) % DEPTH);
  endfunction

  // Transaction model: op 0 none, 1 write-back, 2 refill; cyc = edges since acceptance.
  logic [127:0] m_mem [DEPTH] = '{default: '0};
  int           m_op = 0, m_cyc = 0, m_line = 0;
  bit           m_hold = 1'b0;
  logic [127:0] m_data = '0;
  logic         exp_fin = 1'b1, exp_vld = 1'b0;
  logic [127:0] exp_ldata = '0;
  int           exp_wbc = 0, exp_rdc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_op = 0; m_cyc = 0; m_hold = 1'b0;
      exp_fin = 1'b1; exp_vld = 1'b0; exp_ldata = '0;
      exp_wbc = 0; exp_rdc = 0;
    end else if (m_hold) begin
      if (m_op == 1 && !write_back_enable) begin
        m_hold = 1'b0; m_op = 0;
      end else if (m_op == 2 && !refill_req) begin
        m_hold = 1'b0; m_op = 0; exp_vld = 1'b0;
      end
    end else if (m_op != 0) begin
      m_cyc++;
      if (m_cyc == LAT) begin
        m_hold = 1'b1;
        if (m_op == 1) begin
          m_mem[m_line] = m_data; exp_fin = 1'b1; exp_wbc++;
        end else begin
          exp_ldata = m_mem[m_line]; exp_vld = 1'b1; exp_rdc++;
        end
      end
    end else if (write_back_enable) begin
      m_op = 1; m_cyc = 0; m_line = line_of(write_back_addr);
      m_data = write_back_data; exp_fin = 1'b0;
    end else if (refill_req) begin
      m_op = 2; m_cyc = 0; m_line = line_of(refill_addr);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("finished", 128'(write_back_finished), 128'(exp_fin));
      chk("ldata_valid", 128'(ldata_valid), 128'(exp_vld));
      chk("ldata", ldata, exp_ldata);
`ifdef LINE_MEM_STATS_EN
      chk("wb_count", 128'(wb_count), 128'(exp_wbc));
      chk("refill_count", 128'(refill_count), 128'(exp_rdc));
`endif
    end
  end

  // Address/data are scrambled after acceptance; the DUT must have latched them.
  task automatic do_wb(input logic [31:0] a, input logic [127:0] d, input int hold,
                       output int low_cyc);
    @(negedge clk);
    write_back_enable = 1'b1; write_back_addr = a; write_back_data = d;
    @(negedge clk);
    write_back_addr = a ^ 32'h0000_0FF0; write_back_data = ~d;
    low_cyc = 0;
    while (write_back_finished !== 1'b1 && low_cyc < 50) begin
      @(negedge clk);
      low_cyc++;
    end
    if (low_cyc >= 50) chk("wb_timeout", 128'(low_cyc), 128'(LAT));
    repeat (hold) @(negedge clk);
    write_back_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_rd(input logic [31:0] a, input bit drop_early,
                       output logic [127:0] data, output int lat);
    @(negedge clk);
    refill_req = 1'b1; refill_addr = a;
    @(negedge clk);
    refill_addr = a ^ 32'h0000_0FF0;
    if (drop_early) refill_req = 1'b0;
    lat = 0;
    while (ldata_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) chk("rd_timeout", 128'(lat), 128'(LAT));
    data = ldata;
    refill_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: run did not complete, got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_finished", 128'(write_back_finished), 128'd1);
    chk("reset_valid", 128'(ldata_valid), 128'd0);
    chk("reset_ldata", ldata, 128'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // 1: refill of an unwritten line
    do_rd(32'h4000_0000, 1'b0, d, n);
    chk("t1_latency", 128'(n), 128'd4);
    chk("t1_ldata", d, 128'd0);

    // 2: write-back then refill of the same line
    do_wb(32'h4000_0000, 128'h1010_0000_1C1C_0000_1414_0000_1111, 0, n);
    chk("t2_fin_low_cycles", 128'(n), 128'd4);
    do_rd(32'h4000_0000, 1'b0, d, n);
    chk("t2_ldata", d, 128'h1010_0000_1C1C_0000_1414_0000_1111);

    // 3: simultaneous requests, write-back wins
    @(negedge clk);
    write_back_enable = 1'b1; write_back_addr = 32'hA000_0000; write_back_data = 128'hAAAA;
    refill_req = 1'b1; refill_addr = 32'hA000_0000;
    @(negedge clk);
    n = 0;
    while (write_back_finished !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("t3_fin_low_cycles", 128'(n), 128'd4);
    chk("t3_valid_during_wb", 128'(ldata_valid), 128'd0);
    write_back_enable = 1'b0;
    n = 0;
    while (ldata_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("t3_rd_timeout", 128'(n), 128'(LAT));
    chk("t3_ldata", ldata, 128'hAAAA);
    refill_req = 1'b0;
    @(negedge clk);

    // 4: index aliasing; 0x4000_0000/0xA000_0000 share line 0 with 0x0
    do_wb(32'h0000_0010, 128'h1010, 0, n);
    do_rd(32'h0000_4010, 1'b0, d, n);
    chk("t4_alias", d, 128'h1010);
    do_rd(32'h0000_0000, 1'b0, d, n);
    chk("t4_other_line", d, 128'hAAAA);

    // 5: reset in the middle of a write-back
    @(negedge clk);
    write_back_enable = 1'b1; write_back_addr = 32'hB000_0000; write_back_data = 128'hBBBB;
    repeat (2) @(negedge clk);
    chk("t5_fin_busy", 128'(write_back_finished), 128'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_fin_async", 128'(write_back_finished), 128'd1);
    chk("t5_ldata_async", ldata, 128'd0);
    write_back_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_rd(32'hB000_0000, 1'b0, d, n);
    chk("t5_not_committed", d, 128'hAAAA);

    // 6: held enable must not retrigger; refill dropped while busy still completes
    do_wb(32'h0000_0020, 128'h2020, 10, n);
    chk("t6_fin_low_cycles", 128'(n), 128'd4);
    do_wb(32'h0000_0030, 128'h3030, 0, n);
    do_rd(32'h0000_0020, 1'b0, d, n);
    chk("t6_ldata", d, 128'h2020);
    do_rd(32'h0000_0030, 1'b1, d, n);
    chk("t6_early_drop_latency", 128'(n), 128'd4);
    chk("t6_early_drop_ldata", d, 128'h3030);
    chk("t6_ldata_kept", ldata, 128'h3030);
`ifdef LINE_MEM_STATS_EN
    chk("t6_wb_count", 128'(wb_count), 128'd2);
    chk("t6_refill_count", 128'(refill_count), 128'd3);
`endif
    repeat (3) @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
